cell_instruction_loader: RTL and testbench



---
 rtl/cell_instruction_loader_pkg.sv | 56 +++++
 rtl/cell_instruction_loader_if.sv | 39 +++
 rtl/cell_instruction_loader_fill.sv | 49 ++++
 rtl/cell_instruction_loader.sv | 129 ++++++++++++
 tb/tb_cell_instruction_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cell_instruction_loader_pkg.sv
// Shared types for the cell instruction loader: opcodes, pixel/cell types, FSM states.
// is_unary() is consulted only when UNARY_SKIP_EN is defined.
package cell_instruction_loader_pkg;

    localparam int CELL_SIZE       = 3;
    localparam int CHANNEL_WIDTH   = 8;
    localparam int PIXELS_PER_CELL = CELL_SIZE * CELL_SIZE;
    localparam int FILL_IDX_W      = $clog2(PIXELS_PER_CELL);

    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        MULT  = 4'd2,
        ADDI  = 4'd3,
        SUBI  = 4'd4,
        MULTI = 4'd5,
        DIV2  = 4'd6,
        INV   = 4'd7
    } opcodes_t;

    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0] red;
        logic [CHANNEL_WIDTH-1:0] green;
        logic [CHANNEL_WIDTH-1:0] blue;
    } pixel_t;

    // Indexed [row][col].
    typedef pixel_t [CELL_SIZE-1:0][CELL_SIZE-1:0] pixelMatrix_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        ISSUE  = 2'd3
    } loader_state_t;

    function automatic logic is_unary(input opcodes_t op);
        case (op)
            ADDI, SUBI, MULTI, DIV2, INV: is_unary = 1'b1;
            default:                      is_unary = 1'b0;
        endcase
    endfunction

    function automatic pixel_t unpack_pixel(input logic [3*CHANNEL_WIDTH-1:0] d);
        pixel_t p;
        p.red   = d[RED_LSB   +: CHANNEL_WIDTH];
        p.green = d[GREEN_LSB +: CHANNEL_WIDTH];
        p.blue  = d[BLUE_LSB  +: CHANNEL_WIDTH];
        return p;
    endfunction

endpackage

// File: rtl/cell_instruction_loader_if.sv
// Command, pixel and instruction channels of the loader plus FSM debug taps.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the
// source holds valid and payload stable until then, ready never depends on valid.
interface cell_instruction_loader_if;
    import cell_instruction_loader_pkg::*;

    logic                          cmd_valid;
    logic                          cmd_ready;
    opcodes_t                      cmd_opcode;
    logic [CHANNEL_WIDTH-1:0]      cmd_user;

    logic                          pix_valid;
    logic                          pix_ready;
    logic [3*CHANNEL_WIDTH-1:0]    pix_data;

    logic                          inst_valid;
    logic                          inst_ready;
    pixelMatrix_t                  inst_cellA;
    pixelMatrix_t                  inst_cellB;
    logic [CHANNEL_WIDTH-1:0]      inst_user;
    opcodes_t                      inst_opcode;

    logic                          busy;
    loader_state_t                 dbg_state;
    logic [FILL_IDX_W-1:0]         dbg_fill_idx;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_user, pix_valid, pix_data, inst_ready,
        output cmd_ready, pix_ready, inst_valid, inst_cellA, inst_cellB,
               inst_user, inst_opcode, busy, dbg_state, dbg_fill_idx
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_user, pix_valid, pix_data, inst_ready,
        input  cmd_ready, pix_ready, inst_valid, inst_cellA, inst_cellB,
               inst_user, inst_opcode, busy, dbg_state, dbg_fill_idx
    );

endinterface

// File: rtl/cell_instruction_loader_fill.sv
// cell_fill_counter: row-major row/col position inside a DIM x DIM cell,
// both wrapping mod DIM so no divider is needed.
module cell_fill_counter #(
    parameter int DIM = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   inc_i,
    output logic [$clog2(DIM)-1:0] row_o,
    output logic [$clog2(DIM)-1:0] col_o,
    output logic                   last_o
);
    localparam int W = $clog2(DIM);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == W'(DIM - 1)) begin
                col_d = '0;
                row_d = (row_q == W'(DIM - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == W'(DIM - 1)) && (col_q == W'(DIM - 1));

endmodule

// File: rtl/cell_instruction_loader.sv
// Collects one command and 18 pixels into operand cells A/B and issues them as a bundle.
// UNARY_SKIP_EN: single-operand opcodes issue straight after cell A with cell B zeroed.
module cell_instruction_loader
    import cell_instruction_loader_pkg::*;
#(
    parameter int CELL_DIM  = CELL_SIZE,
    parameter int CHANNEL_W = CHANNEL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    cell_instruction_loader_if.slave  bus
);
    localparam int RC_W = $clog2(CELL_DIM);

    loader_state_t          state_q, state_d;
    logic                   inst_valid_q, inst_valid_d;
    pixelMatrix_t           cell_a_q, cell_a_d;
    pixelMatrix_t           cell_b_q, cell_b_d;
    logic [CHANNEL_W-1:0]   user_q, user_d;
    opcodes_t               opcode_q, opcode_d;

    logic                   cmd_ready;
    logic                   pix_ready;
    logic                   cnt_clear;
    logic                   cnt_inc;
    logic [RC_W-1:0]        row;
    logic [RC_W-1:0]        col;
    logic                   cell_last;
    pixel_t                 pix;

    assign pix = unpack_pixel(bus.pix_data);

    // Wraps on the 9th pixel of each cell, so it is back at 0 for the next cell.
    cell_fill_counter #(.DIM(CELL_DIM)) u_fill (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .row_o   (row),
        .col_o   (col),
        .last_o  (cell_last)
    );

    always_comb begin
        state_d   = state_q;
        cell_a_d  = cell_a_q;
        cell_b_d  = cell_b_q;
        user_d    = user_q;
        opcode_d  = opcode_q;
        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    opcode_d  = bus.cmd_opcode;
                    user_d    = bus.cmd_user;
                    cnt_clear = 1'b1;
                    state_d   = LOAD_A;
                end
            end
            LOAD_A: begin
                pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    cell_a_d[row][col] = pix;
                    cnt_inc            = 1'b1;
                    if (cell_last) begin
`ifdef UNARY_SKIP_EN
                        state_d = is_unary(opcode_q) ? ISSUE : LOAD_B;
`else
                        state_d = LOAD_B;
`endif
                    end
                end
            end
            LOAD_B: begin
                pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    cell_b_d[row][col] = pix;
                    cnt_inc            = 1'b1;
                    if (cell_last) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_valid_q && bus.inst_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inst_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            cell_a_q     <= '0;
            cell_b_q     <= '0;
            user_q       <= '0;
            opcode_q     <= ADD;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            cell_a_q     <= cell_a_d;
            cell_b_q     <= cell_b_d;
            user_q       <= user_d;
            opcode_q     <= opcode_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.pix_ready    = pix_ready;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.inst_cellA   = cell_a_q;
`ifdef UNARY_SKIP_EN
    assign bus.inst_cellB   = is_unary(opcode_q) ? '0 : cell_b_q;
`else
    assign bus.inst_cellB   = cell_b_q;
`endif
    assign bus.inst_user    = user_q;
    assign bus.inst_opcode  = opcode_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.dbg_state    = state_q;
    assign bus.dbg_fill_idx = FILL_IDX_W'(row) * FILL_IDX_W'(CELL_DIM) + FILL_IDX_W'(col);

endmodule

// File: tb/tb_cell_instruction_loader.sv
// Directed bench for cell_instruction_loader: scoreboard of expected bundles,
// immediate-assertion checks, one summary line at the end.
module tb_cell_instruction_loader;
    import cell_instruction_loader_pkg::*;

    localparam int W = 2 * $bits(pixelMatrix_t) + CHANNEL_WIDTH + $bits(opcodes_t);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cell_instruction_loader_if bus();

    cell_instruction_loader #(.CELL_DIM(3), .CHANNEL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int issue_cnt    = 0;
    int valid_cycles = 0;
    int cmd_edge     = 0;
    int issue_edge   = 0;
    pixelMatrix_t ma, mb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        fails++;
        $error("FAIL %s timed out", tag);
    endtask

    function automatic logic [23:0] pix_of(input int k);
        return {8'(k), 8'(k + 1), 8'(k + 2)};
    endfunction

    function automatic logic [W-1:0] bundle(input pixelMatrix_t a, input pixelMatrix_t b,
                                            input logic [7:0] u, input opcodes_t op);
        return {a, b, u, op};
    endfunction

    // Model placement: pixel k of the 18-pixel stream, row-major, A then B.
    task automatic model_put(input int k, input logic [23:0] d);
        if (k < 9) ma[k / 3][k % 3] = d;
        else       mb[(k - 9) / 3][(k - 9) % 3] = d;
    endtask

    // Scoreboard side: an issue handshake happens on the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && bus.inst_valid) valid_cycles++;
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            issue_edge = cyc + 1;
            issue_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL unexpected_issue opcode=%0d", bus.inst_opcode);
            end else begin
                check("bundle", {bus.inst_cellA, bus.inst_cellB, bus.inst_user, bus.inst_opcode},
                      exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input opcodes_t op, input logic [7:0] u);
        int n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_user   = u;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("cmd_handshake");
        cmd_edge = cyc + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] d);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        while (!bus.pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("pix_handshake");
        @(negedge clk);
        bus.pix_valid = 1'b0;
    endtask

    // mode 0: deterministic pix_of(base+k); otherwise random data.
    task automatic load_pixels(input int first, input int count, input int base,
                               input int mode, input int gap);
        logic [23:0] d;
        for (int k = first; k < first + count; k++) begin
            d = (mode == 0) ? pix_of(base + k) : 24'($urandom);
            model_put(k, d);
            send_pix(d);
            if (k != first + count - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout(tag);
    endtask

    initial begin
        int issues_before;
        logic [W-1:0] e;

        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = ADD;
        bus.cmd_user   = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.inst_ready = 1'b0;
        ma = '0;
        mb = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_state", bus.dbg_state, IDLE);
        check("rst_opcode", bus.inst_opcode, ADD);
        check("rst_user", bus.inst_user, 0);
        check("rst_cells", {bus.inst_cellA, bus.inst_cellB}, 0);

        // Basic ADD, no bubbles, execute stage always ready
        bus.inst_ready = 1'b1;
        valid_cycles = 0;
        send_cmd(ADD, 8'h05);
        load_pixels(0, 18, 0, 0, 0);
        exp_q.push_back(bundle(ma, mb, 8'h05, ADD));
        check("add_valid", bus.inst_valid, 1);
        check("add_a12_red", bus.inst_cellA[1][2].red, 5);
        check("add_b00_blue", bus.inst_cellB[0][0].blue, 11);
        check("add_user", bus.inst_user, 8'h05);
        check("add_cmd_ready_issue", bus.cmd_ready, 0);
        @(negedge clk);
        check("add_valid_drop", bus.inst_valid, 0);
        check("add_valid_one_cycle", valid_cycles, 1);
        check("add_issue_latency", issue_edge - cmd_edge, 19);
        check("add_back_to_idle", bus.cmd_ready, 1);

        // Backpressure: five stalled cycles in ISSUE
        bus.inst_ready = 1'b0;
        send_cmd(SUB, 8'hA3);
        load_pixels(0, 18, 0, 1, 0);
        e = bundle(ma, mb, 8'hA3, SUB);
        exp_q.push_back(e);
        repeat (5) begin
            check("bp_valid", bus.inst_valid, 1);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_pix_ready", bus.pix_ready, 0);
            check("bp_hold", {bus.inst_cellA, bus.inst_cellB, bus.inst_user, bus.inst_opcode}, e);
            @(negedge clk);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("bp_release_state", bus.dbg_state, IDLE);
        check("bp_release_valid", bus.inst_valid, 0);
        check("bp_release_busy", bus.busy, 0);

        // Pixels offered while idle are ignored; then a bubbly stream
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'hDEADBE;
        repeat (3) @(negedge clk);
        bus.pix_valid = 1'b0;
        check("idle_pix_ignored_idx", bus.dbg_fill_idx, 0);
        check("idle_pix_ignored_state", bus.dbg_state, IDLE);
        send_cmd(MULT, 8'h3C);
        load_pixels(0, 18, 100, 0, 1);
        exp_q.push_back(bundle(ma, mb, 8'h3C, MULT));
        check("bub_a00", bus.inst_cellA[0][0], pix_of(100));
        check("bub_b00_is_pix9", bus.inst_cellB[0][0], pix_of(109));
        check("bub_b22", bus.inst_cellB[2][2], pix_of(117));
        wait_idle("bub_idle");

        // Reset in the middle of cell B
        issues_before = issue_cnt;
        valid_cycles = 0;
        send_cmd(SUB, 8'h77);
        load_pixels(0, 13, 200, 0, 0);
        check("mid_state_loadb", bus.dbg_state, LOAD_B);
        check("mid_fill_idx", bus.dbg_fill_idx, 4);
        do_reset();
        ma = '0;
        mb = '0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.inst_valid, 0);
        check("mid_rst_cells", {bus.inst_cellA, bus.inst_cellB}, 0);
        check("mid_no_issue", issue_cnt - issues_before, 0);
        check("mid_no_valid", valid_cycles, 0);
        send_cmd(MULT, 8'h11);
        load_pixels(0, 18, 50, 0, 0);
        exp_q.push_back(bundle(ma, mb, 8'h11, MULT));
        check("mid_reload_valid", bus.inst_valid, 1);
        wait_idle("mid_idle");

        // Unary opcode
        send_cmd(INV, 8'h99);
        load_pixels(0, 9, 30, 0, 0);
`ifdef UNARY_SKIP_EN
        exp_q.push_back(bundle(ma, '0, 8'h99, INV));
        check("inv_valid_after_9", bus.inst_valid, 1);
        check("inv_cellb_zero", bus.inst_cellB, 0);
`else
        check("inv_no_valid_after_9", bus.inst_valid, 0);
        check("inv_still_loading", bus.dbg_state, LOAD_B);
        load_pixels(9, 9, 30, 0, 0);
        exp_q.push_back(bundle(ma, mb, 8'h99, INV));
        check("inv_valid_after_18", bus.inst_valid, 1);
        check("inv_b00", bus.inst_cellB[0][0], pix_of(39));
`endif
        wait_idle("inv_idle");

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("issue_count", issue_cnt, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
